cpu_prefetch: RTL and testbench

- Parametrised successor to the moxie instruction fetch unit.
- Fetches 32-bit big-endian words from instruction memory over a req/ack handshake into a halfword prefetch queue.
- Assembles variable-length moxie instructions: a 16-bit opcode, optionally followed by a 32-bit operand.
- Supports branch redirect/flush and delivers one decoded-length instruction per cycle, with its PC, to the decode stage.

---
 rtl/cpu_prefetch.sv | 92 +++++++++
 tb/tb_cpu_prefetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_prefetch.sv
// cpu_prefetch: moxie instruction fetch unit with a halfword prefetch queue, variable-length
// instruction assembly and branch redirect/flush.
module cpu_prefetch #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_1000,
  parameter int          DEPTH_LOG2   = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [15:0] opcode_o,
  output logic [31:0] operand_o,
  output logic [31:0] pc_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;
  state_t state, state_nx;
  logic [15:0] q_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nx, push_n, pop_n;
  logic [31:0] fetch_addr, fetch_nx, req_addr, pc;
  logic [15:0] h0, h1, h2;
  logic drop_first, is_long, consume, ack_ok, space_after;
  assign h0 = q_mem[rd_ptr];
  assign h1 = q_mem[rd_ptr + DEPTH_LOG2'(1)];
  assign h2 = q_mem[rd_ptr + DEPTH_LOG2'(2)];
  assign is_long = !h0[15] && (h0[15:8] inside {8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A,
    8'h1B, 8'h1D, 8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39});
  assign valid_o = is_long ? (count >= CW'(3)) : (count != '0);
  assign opcode_o = valid_o ? h0 : '0;
  assign operand_o = (valid_o && is_long) ? {h1, h2} : '0;
  assign pc_o = pc;
  assign imem_addr_o = req_addr;
  // A branch overrides both the consume and any data arriving in the same cycle
  assign consume = valid_o && !stall_i && !branch_i;
  assign ack_ok = (state == REQ) && imem_ack_i && !branch_i;
  assign push_n = ack_ok ? (drop_first ? CW'(1) : CW'(2)) : '0;
  assign pop_n = consume ? (is_long ? CW'(3) : CW'(1)) : '0;
  assign count_nx = branch_i ? '0 : count + push_n - pop_n;
  assign space_after = count_nx <= CW'(DEPTH - 2);
  assign fetch_nx = branch_i ? {branch_target_i[31:2], 2'b00} : ack_ok ? fetch_addr + 32'd4 : fetch_addr;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (!branch_i && count <= CW'(DEPTH - 2)) ? REQ : IDLE;
      REQ:     state_nx = branch_i ? (imem_ack_i ? IDLE : FLUSH) : !imem_ack_i ? REQ : space_after ? REQ : IDLE;
      FLUSH:   state_nx = imem_ack_i ? IDLE : FLUSH;
      default: state_nx = IDLE;
    endcase
  end
  always_comb imem_req_o = state != IDLE;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_addr <= BOOT_ADDRESS & ~32'd3;
      fetch_addr <= BOOT_ADDRESS & ~32'd3;
      pc <= BOOT_ADDRESS;
      drop_first <= BOOT_ADDRESS[1];
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      // The request address only moves when a new request is launched, so it holds through FLUSH
      if (state_nx == REQ && (state == IDLE || imem_ack_i)) req_addr <= fetch_nx;
      fetch_addr <= fetch_nx;
      pc <= branch_i ? {branch_target_i[31:1], 1'b0} : consume ? pc + (is_long ? 32'd6 : 32'd2) : pc;
      drop_first <= branch_i ? branch_target_i[1] : ack_ok ? 1'b0 : drop_first;
      rd_ptr <= branch_i ? '0 : rd_ptr + pop_n[DEPTH_LOG2-1:0];
      wr_ptr <= branch_i ? '0 : wr_ptr + push_n[DEPTH_LOG2-1:0];
      count <= count_nx;
    end
  end
  always_ff @(posedge clk_i) begin
    if (ack_ok) begin
      if (drop_first) q_mem[wr_ptr] <= imem_data_i[15:0];
      else begin
        q_mem[wr_ptr] <= imem_data_i[31:16];
        q_mem[wr_ptr + DEPTH_LOG2'(1)] <= imem_data_i[15:0];
      end
    end
  end
endmodule

// File: tb/tb_cpu_prefetch.sv
// tb_cpu_prefetch: directed checks of cpu_prefetch against a behavioural instruction memory.
module tb_cpu_prefetch;
  logic clk_i = 0, rst_ni = 0, imem_ack_i = 0, branch_i = 0, stall_i = 1;
  logic [31:0] imem_data_i = '0, branch_target_i = '0;
  logic imem_req_o, valid_o;
  logic [31:0] imem_addr_o, operand_o, pc_o;
  logic [15:0] opcode_o;
  int total = 0, bad = 0, wc = 0, wait_cfg = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ack_addrs [$];
  typedef struct {logic [15:0] op; logic [31:0] opr; logic [31:0] pc;} vec_t;
  vec_t vecs [11];

  cpu_prefetch dut (.clk_i(clk_i), .rst_ni(rst_ni), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .stall_i(stall_i), .valid_o(valid_o), .opcode_o(opcode_o),
    .operand_o(operand_o), .pc_o(pc_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h2600_2601;
  endfunction

  // memory responder: acks each request after wait_cfg idle cycles
  initial forever begin
    @(negedge clk_i);
    if (!rst_ni) begin
      imem_ack_i = 0;
      wc = 0;
    end else begin
      if (imem_ack_i) wc = 0;
      if (imem_req_o && wc == wait_cfg) begin
        imem_ack_i = 1;
        imem_data_i = rd(imem_addr_o);
        ack_addrs.push_back(imem_addr_o);
      end else begin
        imem_ack_i = 0;
        if (imem_req_o) wc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni = 0;
    branch_i = 0;
    stall_i = 1;
    ack_addrs.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".req"}, 32'(imem_req_o), 0);
    chk({nm, ".addr"}, imem_addr_o, 32'h1000);
    chk({nm, ".valid"}, 32'(valid_o), 0);
    chk({nm, ".opcode"}, 32'(opcode_o), 0);
    chk({nm, ".operand"}, operand_o, 0);
    chk({nm, ".pc"}, pc_o, 32'h1000);
  endtask

  task automatic take(input string nm, input logic [15:0] op, input logic [31:0] opr, input logic [31:0] pc);
    int i = 0;
    while (!valid_o && i < 20) begin
      @(negedge clk_i);
      i++;
    end
    if (!valid_o) begin
      total++;
      bad++;
      $display("FAIL %s: valid_o=0 after 20 cycles, expected 1", nm);
    end else begin
      chk({nm, ".op"}, 32'(opcode_o), 32'(op));
      chk({nm, ".operand"}, operand_o, opr);
      chk({nm, ".pc"}, pc_o, pc);
      stall_i = 0;
      @(negedge clk_i);
      stall_i = 1;
    end
  endtask

  initial begin
    vecs = '{'{16'h2612, 32'h0, 32'h1000}, '{16'h2634, 32'h0, 32'h1002},
             '{16'h0120, 32'hDEADBEEF, 32'h1004}, '{16'h0900, 32'h12345678, 32'h100A},
             '{16'h8100, 32'h0, 32'h1010}, '{16'h3600, 32'hCAFEF00D, 32'h1012},
             '{16'h0500, 32'h0, 32'h1018}, '{16'h1F00, 32'h00000001, 32'h101A},
             '{16'h2600, 32'h0, 32'h1020}, '{16'h2601, 32'h0, 32'h1022},
             '{16'h2600, 32'h0, 32'h1024}};
    // instruction stream and reset/latency
    mem[32'h1000] = 32'h2612_2634; mem[32'h1004] = 32'h0120_DEAD; mem[32'h1008] = 32'hBEEF_0900;
    mem[32'h100C] = 32'h1234_5678; mem[32'h1010] = 32'h8100_3600; mem[32'h1014] = 32'hCAFE_F00D;
    mem[32'h1018] = 32'h0500_1F00; mem[32'h101C] = 32'h0000_0001;
    @(negedge clk_i);
    chk_reset("rst");
    do_reset();
    @(negedge clk_i);
    chk("first_req", 32'(imem_req_o), 1);
    chk("first_addr", imem_addr_o, 32'h1000);
    @(negedge clk_i);
    chk("first_valid", 32'(valid_o), 1);
    for (int k = 0; k < 11; k++) take($sformatf("seq%0d", k), vecs[k].op, vecs[k].opr, vecs[k].pc);
    // stall fills the queue: 4 words then no request
    mem.delete();
    do_reset();
    repeat (30) @(negedge clk_i);
    chk("stall_fetches", 32'(ack_addrs.size()), 4);
    chk("stall_req", 32'(imem_req_o), 0);
    stall_i = 0;
    @(negedge clk_i);
    stall_i = 1;
    repeat (5) @(negedge clk_i);
    chk("pop1_fetches", 32'(ack_addrs.size()), 4);
    stall_i = 0;
    @(negedge clk_i);
    stall_i = 1;
    repeat (5) @(negedge clk_i);
    chk("pop2_fetches", 32'(ack_addrs.size()), 5);
    // branch during a waiting request, then a second branch during flush
    mem[32'h1000] = 32'h1111_2222;
    mem[32'h2000] = 32'hAAAA_2634;
    wait_cfg = 3;
    do_reset();
    @(negedge clk_i);
    branch_i = 1;
    branch_target_i = 32'h3000;
    @(negedge clk_i);
    chk("flush_req", 32'(imem_req_o), 1);
    chk("flush_addr", imem_addr_o, 32'h1000);
    chk("flush_valid", 32'(valid_o), 0);
    chk("flush_pc", pc_o, 32'h3000);
    branch_target_i = 32'h2003;
    @(negedge clk_i);
    branch_i = 0;
    chk("flush2_addr", imem_addr_o, 32'h1000);
    chk("flush2_pc", pc_o, 32'h2002);
    take("br", 16'h2634, 32'h0, 32'h2002);
    chk("br_refetch", ack_addrs.size() > 1 ? ack_addrs[1] : 32'hFFFF_FFFF, 32'h2000);
    // branch coincident with ack and consume
    wait_cfg = 0;
    mem.delete();
    mem[32'h1000] = 32'h2612_2634;
    mem[32'h3004] = 32'h2634_2612;
    do_reset();
    repeat (2) @(negedge clk_i);
    chk("co_pre_valid", 32'(valid_o), 1);
    stall_i = 0;
    branch_i = 1;
    branch_target_i = 32'h3004;
    @(negedge clk_i);
    branch_i = 0;
    stall_i = 1;
    chk("co_valid", 32'(valid_o), 0);
    chk("co_pc", pc_o, 32'h3004);
    chk("co_req", 32'(imem_req_o), 0);
    take("co0", 16'h2634, 32'h0, 32'h3004);
    take("co1", 16'h2612, 32'h0, 32'h3006);
    // asynchronous reset while a request is outstanding
    do_reset();
    @(negedge clk_i);
    #2 wait_cfg = 7;
    @(negedge clk_i);
    chk("ar_pre_valid", 32'(valid_o), 1);
    stall_i = 0;
    @(negedge clk_i);
    stall_i = 1;
    #2;
    chk("ar_pre_req", 32'(imem_req_o), 1);
    chk("ar_pre_pc", pc_o, 32'h1002);
    rst_ni = 0;
    #1;
    chk_reset("arst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
